// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared SPI types and constants (master + receive stage). Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int   SPI_WORD_W = 8;

    localparam logic SCLK_IDLE  = 1'b0;
    localparam logic CS_IDLE    = 1'b1;
    localparam logic MOSI_IDLE  = 1'b0;

    typedef enum logic [1:0] {
        MST_IDLE  = 2'd0,
        MST_LEAD  = 2'd1,
        MST_TRAIL = 2'd2,
        MST_DONE  = 2'd3
    } mst_state_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_rx_fifo : receive word FIFO with registered head and sticky overflow. Rev 1.0
// ---------------------------------------------------------------------------
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       clr_ovf_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_d;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (level_q == LW'(DEPTH));
        do_pop  = pop_i && (level_q != '0);
        do_push = push_i && (!full || do_pop);
        rptr_d  = do_pop ? (rptr_q + AW'(1)) : rptr_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        // The slot being written can become the new head in the same cycle
        head_d  = (do_push && (wptr_q == rptr_d)) ? push_data_i : mem_q[rptr_d];
        ovf_d   = (push_i && full && !do_pop) || (ovf_q && !clr_ovf_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head_o     = head_q;
    assign valid_o    = (level_q != '0);
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_rx : mode-0 SPI receiver, oversampled in clk, words into a FIFO.
// Build option: SPI_RX_LSB_FIRST_EN selects LSB-first word assembly. Rev 1.0
// ---------------------------------------------------------------------------
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output logic [WIDTH-1:0]       rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;
    logic                   sclk_rise_q;
    logic                   cs_rise_q;
    logic                   cs_fall_q;
    logic                   mosi_bit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            cs_sync_q   <= {SYNC_STAGES{CS_IDLE}};
            mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
            sclk_dly_q  <= SCLK_IDLE;
            cs_dly_q    <= CS_IDLE;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_bit_q  <= MOSI_IDLE;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
            // mosi is captured at the synchroniser depth where the sclk edge is seen
            sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
            cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_dly_q;
            cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1] & cs_dly_q;
            mosi_bit_q  <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    rx_state_t          state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic               push_q;
    logic [WIDTH-1:0]   push_data_q;
    logic               frame_err_q;

    always_comb begin
`ifdef SPI_RX_LSB_FIRST_EN
        shift_d = {mosi_bit_q, shift_q[WIDTH-1:1]};
`else
        shift_d = {shift_q[WIDTH-2:0], mosi_bit_q};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (cs_fall_q) begin
                        state_q   <= RX_SHIFT;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                RX_SHIFT: begin
                    // cs release wins over a coincident sclk rise
                    if (cs_rise_q) begin
                        state_q     <= RX_IDLE;
                        frame_err_q <= (bit_cnt_q != '0);
                        bit_cnt_q   <= '0;
                    end else if (sclk_rise_q) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            push_q      <= 1'b1;
                            push_data_q <= shift_d;
                            bit_cnt_q   <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    spi_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (rx_ready),
        .clr_ovf_i   (clr_ovf),
        .head_o      (rx_data),
        .valid_o     (rx_valid),
        .level_o     (fifo_level),
        .overflow_o  (overflow)
    );

    assign busy      = ~cs_sync_q[SYNC_STAGES-1];
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_slave_rx : directed self-checking bench for spi_slave_rx. Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [2:0]       fifo_level;
    logic             busy;
    logic             frame_err;
    logic             overflow;
    logic             clr_ovf;

    int               n_vec     = 0;
    int               n_err     = 0;
    int               fe_cycles = 0;
    int               fe0;
    logic [7:0]       popq[$];

    spi_slave_rx #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) popq.push_back(rx_data);
        if (frame_err) fe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_w(input logic [7:0] w);
        logic [7:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic logic [7:0] popq_at(input int i);
        return (i < popq.size()) ? popq[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        cs = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] w);
        frame_start();
        send_bits(w, 7, 0);
        frame_end();
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick(DEPTH + 2);
        rx_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        rx_ready = 1'b0; clr_ovf = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick(2);

        // single word with latency probe on the final bit
        frame_start();
        check("t1_busy", busy, 1);
        send_bits(8'hAA, 7, 1);
        mosi = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
        check("t1_lat_early", rx_valid, 0);
        tick(1);
        check("t1_lat_valid", rx_valid, 1);
        sclk = 1'b0;
        frame_end();
        check("t1_data", rx_data, exp_w(8'hAA));
        check("t1_level", fifo_level, 1);
        check("t1_ferr", fe_cycles, 0);
        popq.delete();
        drain();
        check("t1_popn", popq.size(), 1);
        check("t1_pop0", popq_at(0), exp_w(8'hAA));

        // two words in one frame, consumer always ready
        popq.delete();
        rx_ready = 1'b1;
        frame_start();
        send_bits(8'h5A, 7, 0);
        send_bits(8'hC3, 7, 0);
        frame_end();
        rx_ready = 1'b0;
        check("t2_popn", popq.size(), 2);
        check("t2_pop0", popq_at(0), exp_w(8'h5A));
        check("t2_pop1", popq_at(1), exp_w(8'hC3));
        check("t2_ferr", fe_cycles, 0);

        // partial word then a good one
        fe0 = fe_cycles;
        frame_start();
        send_bits(8'h05, 2, 0);
        frame_end();
        check("t3_ferr_cycles", fe_cycles - fe0, 1);
        check("t3_nopush", fifo_level, 0);
        send_frame(8'h0F);
        check("t3_data", rx_data, exp_w(8'h0F));
        check("t3_level", fifo_level, 1);
        drain();

        // overflow
        popq.delete();
        frame_start();
        for (int w = 1; w <= 5; w++) send_bits(8'(w), 7, 0);
        frame_end();
        check("t4_level", fifo_level, 4);
        check("t4_ovf", overflow, 1);
        drain();
        check("t4_popn", popq.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t4_pop%0d", i), popq_at(i), exp_w(8'(i + 1)));
        check("t4_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        tick(1);
        check("t4_ovf_clr", overflow, 0);

        // full FIFO, pop coincides with the push of 0x77
        frame_start();
        for (int w = 1; w <= 4; w++) send_bits(8'(w * 8'h11), 7, 0);
        frame_end();
        check("t5_full", fifo_level, 4);
        popq.delete();
        frame_start();
        send_bits(8'h77, 7, 1);
        mosi = 1'b1;
        tick(4);
        sclk = 1'b1;
        tick(4);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        sclk = 1'b0;
        check("t5_level", fifo_level, 4);
        check("t5_ovf", overflow, 0);
        check("t5_head", rx_data, exp_w(8'h22));
        frame_end();
        drain();
        check("t5_popn", popq.size(), 5);
        check("t5_pop0", popq_at(0), exp_w(8'h11));
        check("t5_pop4", popq_at(4), exp_w(8'h77));

        // sclk noise with cs high
        fe0 = fe_cycles;
        for (int i = 0; i < 10; i++) send_bit(1'(i));
        tick(8);
        check("t6_noise_level", fifo_level, 0);
        check("t6_noise_busy", busy, 0);

        // reset in the middle of a word
        send_frame(8'h99);
        check("t6_pre_level", fifo_level, 1);
        frame_start();
        send_bits(8'hF0, 7, 4);
        rst = 1'b1;
        cs = 1'b1;
        sclk = 1'b0;
        tick(2);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_busy", busy, 0);
        rst = 1'b0;
        tick(6);
        check("t6_rst_ferr", fe_cycles - fe0, 0);
        send_frame(8'h3C);
        check("t6_data", rx_data, exp_w(8'h3C));
        check("t6_level", fifo_level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
